// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with redirect/kill handling.
// Optional retired-instruction counter enabled by macro FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_LAT_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, REQ, KILL, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] redir_tgt;

  assign redir_tgt = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    inst_data_d = inst_data_q;
    inst_pc_d   = inst_pc_q;
    case (state_q)
      IDLE: begin
        if (redirect_valid) pc_d = redir_tgt;
        state_d = REQ;
      end
      REQ: begin
        if (mem_ack) begin
          if (redirect_valid) begin
            pc_d    = redir_tgt;
            state_d = REQ;
          end else begin
            inst_data_d = mem_rdata;
            inst_pc_d   = pc_q;
            state_d     = HOLD;
          end
        end else if (redirect_valid) begin
          // pc moves on, but the in-flight address must stay on the bus
          kill_addr_d = pc_q;
          pc_d        = redir_tgt;
          state_d     = KILL;
        end
      end
      KILL: begin
        if (redirect_valid) pc_d = redir_tgt;
        if (mem_ack) state_d = REQ;
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = REQ;
        end else if (inst_ready) begin
          pc_d    = inst_pc_q + 32'd4;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      kill_addr_q <= '0;
      inst_data_q <= '0;
      inst_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      inst_data_q <= inst_data_d;
      inst_pc_q   <= inst_pc_d;
    end
  end

  always_comb begin
    mem_req  = (state_q == REQ) || (state_q == KILL);
    mem_addr = '0;
    if (state_q == REQ)  mem_addr = pc_q;
    if (state_q == KILL) mem_addr = kill_addr_q;
  end

  assign inst_valid = (state_q == HOLD);
  assign inst_data  = inst_data_q;
  assign inst_pc    = inst_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        handshake;

  // A redirect coinciding with inst_ready still retires the held instruction
  always_comb begin
    handshake     = (state_q == HOLD) && inst_ready;
    fetch_count_d = fetch_count_q + {31'd0, handshake};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_count_q <= '0;
    else     fetch_count_q <= fetch_count_d;
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// memory latency, back-pressure, redirects, stray acks and mid-run resets.
module tb_fetch_unit;

  localparam int unsigned MEM_LAT_MAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] fetch_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .MEM_LAT_MAX(MEM_LAT_MAX)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  // Transaction-level model: next fetch pc, one optional outstanding request,
  // one optional held instruction, retired count.
  bit          m_started, m_out, m_discard, m_have;
  logic [31:0] m_pc, m_out_addr, m_inst, m_inst_pc, m_count;

  task automatic model_reset();
    m_started = 0; m_out = 0; m_discard = 0; m_have = 0;
    m_pc = 32'h0; m_out_addr = '0; m_inst = '0; m_inst_pc = '0; m_count = '0;
  endtask

  task automatic issue();
    m_out = 1; m_out_addr = m_pc; m_discard = 0;
  endtask

  task automatic model_edge(input bit ack, input logic [31:0] data, input bit ready,
                            input bit redir, input logic [31:0] rpc);
    logic [31:0] tgt;
    tgt = {rpc[31:2], 2'b00};
    if (!m_started) begin
      if (redir) m_pc = tgt;
      m_started = 1;
      issue();
    end else if (m_out) begin
      if (ack) begin
        m_out = 0;
        if (!m_discard && !redir) begin
          m_have = 1; m_inst = data; m_inst_pc = m_out_addr;
        end
      end else if (redir) m_discard = 1;
      if (redir) m_pc = tgt;
      if (ack && !m_have) issue();
    end else if (m_have) begin
      if (ready || redir) begin
`ifdef FETCH_PERF_CNT_EN
        if (ready) m_count = m_count + 1;
`endif
        m_have = 0;
        m_pc = redir ? tgt : m_inst_pc + 32'd4;
        issue();
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req",     {31'd0, mem_req},    {31'd0, m_out});
      check("mem_addr",    mem_addr,            m_out ? m_out_addr : 32'h0);
      check("inst_valid",  {31'd0, inst_valid}, {31'd0, m_have});
      check("inst_data",   inst_data,           m_inst);
      check("inst_pc",     inst_pc,             m_inst_pc);
      check("fetch_count", fetch_count,         m_count);
    end
  end

  // Called at a negedge; applies inputs for one cycle and returns at the next negedge.
  task automatic step(input bit ack, input logic [31:0] data, input bit ready,
                      input bit redir, input logic [31:0] rpc);
    mem_ack = ack; mem_rdata = data; inst_ready = ready;
    redirect_valid = redir; redirect_pc = rpc;
    @(posedge clk);
    if (!rst) model_edge(ack, data, ready, redir, rpc);
    @(negedge clk);
  endtask

  task automatic hold_reset_and_release();
    mem_ack = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    mem_ack = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst_mem_req_now",     {31'd0, mem_req},    32'd0);
    check("rst_count_now",       fetch_count,         32'd0);
    check("rst_inst_valid_now",  {31'd0, inst_valid}, 32'd0);
    hold_reset_and_release();
  endtask

  logic [31:0] exp3;
  int unsigned wait_cnt, lat;
  bit          a;

  initial begin
`ifdef FETCH_PERF_CNT_EN
    exp3 = 32'd3;
`else
    exp3 = 32'd0;
`endif
    model_reset();
    chk_en = 1'b1;
    hold_reset_and_release();

    // Reset released: still IDLE, request follows on the next edge.
    check("idle_after_rst", {31'd0, mem_req}, 32'd0);
    step(0, 32'h0, 1, 0, 32'h0);
    check("first_req", {31'd0, mem_req}, 32'd1);
    check("first_addr", mem_addr, 32'h0);
    step(1, 32'hA000_0001, 1, 0, 32'h0);
    check("hold_data_a", inst_data, 32'hA000_0001);
    check("hold_pc_a", inst_pc, 32'h0);
    step(0, 32'h0, 1, 0, 32'h0);
    check("addr_4", mem_addr, 32'h4);

    // Slow memory: request held for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      step(0, 32'h0, 1, 0, 32'h0);
      check("slow_addr", mem_addr, 32'h4);
      check("slow_no_valid", {31'd0, inst_valid}, 32'd0);
    end
    step(1, 32'hB000_0002, 1, 0, 32'h0);
    check("slow_valid", {31'd0, inst_valid}, 32'd1);

    // Back-pressure for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      step(0, 32'h0, 0, 0, 32'h0);
      check("bp_data", inst_data, 32'hB000_0002);
      check("bp_valid", {31'd0, inst_valid}, 32'd1);
    end
    step(0, 32'h0, 1, 0, 32'h0);
    check("addr_8", mem_addr, 32'h8);

    // Redirect while waiting: request stays, data dropped.
    step(0, 32'h0, 1, 1, 32'h1234_5003);
    check("kill_addr", mem_addr, 32'h8);
    check("kill_req", {31'd0, mem_req}, 32'd1);
    step(1, 32'hDEAD_BEEF, 1, 0, 32'h0);
    check("kill_no_valid", {31'd0, inst_valid}, 32'd0);
    check("redir_addr", mem_addr, 32'h1234_5000);

    // Redirect to top of address space, then wrap.
    step(0, 32'h0, 1, 1, 32'hFFFF_FFFC);
    step(1, 32'h0, 1, 0, 32'h0);
    check("top_addr", mem_addr, 32'hFFFF_FFFC);
    step(1, 32'hC000_0003, 1, 0, 32'h0);
    check("top_pc", inst_pc, 32'hFFFF_FFFC);
    step(0, 32'h0, 1, 0, 32'h0);
    check("wrap_addr", mem_addr, 32'h0);

    // One instruction dropped by redirect in HOLD.
    step(1, 32'hE000_0004, 0, 0, 32'h0);
    step(0, 32'h0, 0, 1, 32'h0000_0100);
    check("drop_no_valid", {31'd0, inst_valid}, 32'd0);
    check("drop_addr", mem_addr, 32'h100);
    check("count_3", fetch_count, exp3);

    mid_reset();

    wait_cnt = 0;
    lat = $urandom_range(0, MEM_LAT_MAX);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        mid_reset();
        wait_cnt = 0;
      end
      a = 1'b0;
      if (m_out) begin
        if (wait_cnt >= lat) begin
          a = 1'b1;
          wait_cnt = 0;
          lat = $urandom_range(0, MEM_LAT_MAX);
        end else wait_cnt++;
      end else a = ($urandom_range(0, 7) == 0);
      step(a, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0, $urandom);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
